// File: rtl/aes_inv_sub_addkey.sv
// Column-serial AES InvSubBytes + AddRoundKey stage: four inverse S-boxes
// are time-shared across the four state columns, one column per cycle.

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x_in, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = x_in;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and 0 maps to 0 without a special case
  function automatic logic [7:0] gf_inv(input logic [7:0] v);
    logic [7:0] sq;
    logic [7:0] r;
    sq = gf_mul(v, v);
    r  = sq;
    for (int i = 0; i < 6; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] aff;

  always_comb begin
    aff = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    y   = gf_inv(aff);
  end
endmodule

module aes_inv_sub_addkey #(
  parameter int unsigned KEY_ADD = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] work_q, work_d;
  logic [127:0] key_q, key_d;
  logic [31:0]  col_in, col_key, sb_out, col_out;

  always_comb begin
    col_in  = work_q[127:96];
    col_key = key_q[127:96];
    case (col_q)
      2'd0: begin col_in = work_q[127:96]; col_key = key_q[127:96]; end
      2'd1: begin col_in = work_q[95:64];  col_key = key_q[95:64];  end
      2'd2: begin col_in = work_q[63:32];  col_key = key_q[63:32];  end
      default: begin col_in = work_q[31:0]; col_key = key_q[31:0]; end
    endcase
  end

  for (genvar r = 0; r < 4; r++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .a(col_in[31-8*r -: 8]),
      .y(sb_out[31-8*r -: 8])
    );
  end

  assign col_out = sb_out ^ ((KEY_ADD != 0) ? col_key : 32'h0);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    key_d   = key_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          key_d   = round_key;
          col_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        case (col_q)
          2'd0: work_d[127:96] = col_out;
          2'd1: work_d[95:64]  = col_out;
          2'd2: work_d[63:32]  = col_out;
          default: work_d[31:0] = col_out;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        // hand-off and new capture share one edge when both sides are ready
        if (out_ready) begin
          if (in_valid) begin
            work_d  = state_in;
            key_d   = round_key;
            col_d   = 2'd0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      work_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
      key_q   <= key_d;
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign state_out = work_q;
endmodule
